imem_banked_fetch: RTL and testbench
====================================

Name: imem_banked_fetch

Overview:
- Parametrised successor to the single-word instruction memory.
- Returns FETCH_WIDTH consecutive instructions per cycle from any word-aligned start address, using FETCH_WIDTH word-interleaved banks.
- Request and response use valid/ready handshakes; response stalls are honoured, and a flush from the redirect logic drops a pending response.
- Sits between the PC/branch-redirect stage and the fetch buffer.
- A write port loads the program.

Parameters:
- ADDR_WIDTH, 32: byte-address width.
- DATA_WIDTH, 32: instruction width in bits.
- DEPTH, 1024: total words. Power of two and a multiple of FETCH_WIDTH.
- FETCH_WIDTH, 2: instructions per fetch. Power of two, from 1 to 8.

Ports:
- clk  in  1: clock; all state updates on the rising edge.
- rst_n  in  1: asynchronous active-low reset.
- i_req_valid  in  1: fetch request valid.
- o_req_ready  out  1: request accepted when i_req_valid && o_req_ready.
- i_req_addr  in  ADDR_WIDTH: fetch byte address; bits [1:0] are ignored.
- i_flush  in  1: drop any pending response (redirect).
- o_rsp_valid  out  1: response valid.
- i_rsp_ready  in  1: consumer takes the response.
- o_rsp_pc  out  ADDR_WIDTH: address of the request, with [1:0] forced to 0.
- o_rsp_data  out  FETCH_WIDTH*DATA_WIDTH: slot k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- o_rsp_mask  out  FETCH_WIDTH: per-slot valid.
- i_wr_en  in  1: program-load write enable.
- i_wr_addr  in  ADDR_WIDTH: write byte address; bits [1:0] are ignored.
- i_wr_data  in  DATA_WIDTH: write data.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - o_rsp_valid=0, o_rsp_pc=0, o_rsp_data=0, o_rsp_mask=0.
  - Memory arrays are not reset.
- Word index: w = i_req_addr[ADDR_WIDTH-1:2] mod DEPTH.
- Bank mapping:
  - Slot k reads word (w+k) mod DEPTH.
  - That word lives in bank (w+k) mod FETCH_WIDTH, row ((w+k) mod DEPTH)/FETCH_WIDTH.
  - Each bank is read at most once per fetch, so any start alignment is served in one access.
  - The fetch wraps at DEPTH: the last word is followed by word 0.
- Ready: o_req_ready = i_flush | !o_rsp_valid | i_rsp_ready. Purely combinational, with no combinational path from i_req_valid.
- Latency:
  - A request accepted in cycle N produces o_rsp_valid=1 in cycle N+1, with o_rsp_pc, o_rsp_data and o_rsp_mask registered.
  - Banks and the response registers are enabled only on accept.
  - Throughput is 1 fetch/cycle while i_rsp_ready=1.
- Stall: while o_rsp_valid && !i_rsp_ready && !i_flush, every response output holds bit-for-bit. Later writes to the fetched words do not alter the held data.
- Response handoff: on i_rsp_ready with no new accept, o_rsp_valid goes to 0 next cycle.
- Flush:
  - i_flush=1 clears o_rsp_valid next cycle, regardless of i_rsp_ready.
  - A request presented in the flush cycle is accepted and becomes the next response (in N+1). Flush has priority over holding.
  - Flush with no pending response is a no-op.
- Write:
  - On i_wr_en, word i_wr_addr[ADDR_WIDTH-1:2] mod DEPTH is written. Writes are independent of handshakes and stalls.
  - On a same-cycle read and write of the same word, the read returns the old data (read-before-write).
- Mask without the optional feature: all ones on every valid response.
- Mask while o_rsp_valid=0: o_rsp_mask keeps its last registered value, and consumers must ignore it.
- Reset mid-operation: a pending response is lost and no stale data appears after rst_n rises.

Optional Feature:
- Macro: IMEM_FETCH_LINE_CLIP_EN.
- Defined:
  - Slot k is valid only if (w mod FETCH_WIDTH)+k < FETCH_WIDTH, i.e. the fetch is clipped at the aligned fetch-line boundary. This is for predictors indexed per line.
  - o_rsp_data for clipped slots still carries the wrapped words.
- Undefined: o_rsp_mask is all ones.

Test Plan (FETCH_WIDTH=2, DEPTH=16, word i preloaded with 0x100+i):
- Aligned fetch: accept addr 0x08 with rsp_ready=1 -> next cycle valid=1, pc=0x08, data={0x103,0x102}, mask=2'b11.
- Misaligned and wrap:
  - Addr 0x0C -> data={0x104,0x103}; mask=2'b11, or 2'b01 with IMEM_FETCH_LINE_CLIP_EN.
  - Addr 0x3C -> data={0x100,0x10F}.
- Stall:
  - Accept 0x00, then hold rsp_ready=0 for 3 cycles while req_valid=1 with addr 0x10 -> req_ready=0; outputs fixed at pc=0x00, data={0x101,0x100}.
  - Raise rsp_ready -> the 0x10 request is accepted in that cycle; response pc=0x10 follows next cycle.
- Flush during stall: pending pc=0x00 and rsp_ready=0; pulse flush with req 0x20 -> next cycle valid=1, pc=0x20, data={0x109,0x108}. The old response is never handed off.
- Write collision: same cycle write word 5 = 0xDEAD and fetch addr 0x14 -> response slot0=0x105; a refetch of 0x14 gives slot0=0xDEAD.
- Async reset: assert rst_n=0 mid-response, between clock edges -> o_rsp_valid=0 immediately, and it stays 0 in the first cycle after release with no request.

Source files
------------

// File: rtl/imem_banked_fetch.sv
// Banked instruction memory: FETCH_WIDTH consecutive words per fetch,
// any word-aligned start, valid/ready request and response, flush.
// Ports: clk, rst_n (async low); i_req_valid/o_req_ready/i_req_addr;
// i_flush; o_rsp_valid/i_rsp_ready/o_rsp_pc/o_rsp_data/o_rsp_mask;
// i_wr_en/i_wr_addr/i_wr_data program-load write port.
// Macro IMEM_FETCH_LINE_CLIP_EN clips the mask at the fetch-line edge.
module imem_banked_fetch #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int FETCH_WIDTH = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_req_valid,
  output logic                              o_req_ready,
  input  logic [ADDR_WIDTH-1:0]             i_req_addr,
  input  logic                              i_flush,
  output logic                              o_rsp_valid,
  input  logic                              i_rsp_ready,
  output logic [ADDR_WIDTH-1:0]             o_rsp_pc,
  output logic [FETCH_WIDTH*DATA_WIDTH-1:0] o_rsp_data,
  output logic [FETCH_WIDTH-1:0]            o_rsp_mask,
  input  logic                              i_wr_en,
  input  logic [ADDR_WIDTH-1:0]             i_wr_addr,
  input  logic [DATA_WIDTH-1:0]             i_wr_data
);

  localparam int FW   = FETCH_WIDTH;
  localparam int DW   = DATA_WIDTH;
  localparam int WB   = $clog2(DEPTH);
  localparam int FB   = $clog2(FW);
  localparam int ROWS = DEPTH / FW;
  localparam int RBW  = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef logic [WB-1:0]  word_t;
  typedef logic [RBW-1:0] row_t;

  localparam word_t LOMASK = word_t'(FW - 1);

  function automatic row_t row_of(input word_t wd);
    word_t sh;
    sh = wd >> FB;
    return sh[RBW-1:0];
  endfunction

  word_t req_w;
  word_t wr_w;
  word_t wr_bank;
  row_t  wr_row;
  logic  acc;
  logic  valid_q;

  assign req_w   = i_req_addr[WB+1:2];
  assign wr_w    = i_wr_addr[WB+1:2];
  assign wr_bank = wr_w & LOMASK;
  assign wr_row  = row_of(wr_w);

  assign o_req_ready = i_flush | ~valid_q | i_rsp_ready;
  assign acc         = i_req_valid & o_req_ready;

  // Bank b serves the single slot whose word falls in it.
  row_t            rd_row [FW];
  logic [DW-1:0]   rd     [FW];

  always_comb begin
    for (int b = 0; b < FW; b++) begin
      rd_row[b] = row_of(req_w +
        ((word_t'(b) - req_w) & LOMASK));
    end
  end

  for (genvar b = 0; b < FW; b++) begin : g_bank
    logic [DW-1:0] mem [ROWS];

    always_ff @(posedge clk) begin
      if (i_wr_en && wr_bank == word_t'(b))
        mem[wr_row] <= i_wr_data;
    end

    assign rd[b] = mem[rd_row[b]];
  end

  logic [FW-1:0] mask_d;

  always_comb begin
    mask_d = '0;
    for (int k = 0; k < FW; k++) begin
`ifdef IMEM_FETCH_LINE_CLIP_EN
      mask_d[k] = (int'(req_w & LOMASK) + k) < FW;
`else
      mask_d[k] = 1'b1;
`endif
    end
  end

  logic [DW-1:0]         bank_q [FW];
  word_t                 wlo_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [FW-1:0]         mask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      wlo_q   <= '0;
      pc_q    <= '0;
      mask_q  <= '0;
      for (int b = 0; b < FW; b++)
        bank_q[b] <= '0;
    end else begin
      if (acc) begin
        valid_q <= 1'b1;
        wlo_q   <= req_w & LOMASK;
        pc_q    <= {i_req_addr[ADDR_WIDTH-1:2], 2'b00};
        mask_q  <= mask_d;
        for (int b = 0; b < FW; b++)
          bank_q[b] <= rd[b];
      end else if (i_flush || i_rsp_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  // Rotate bank registers into slot order.
  word_t sel;

  always_comb begin
    sel        = '0;
    o_rsp_data = '0;
    for (int k = 0; k < FW; k++) begin
      sel = (wlo_q + word_t'(k)) & LOMASK;
      for (int b = 0; b < FW; b++) begin
        if (sel == word_t'(b))
          o_rsp_data[k*DW +: DW] = bank_q[b];
      end
    end
  end

  assign o_rsp_valid = valid_q;
  assign o_rsp_pc    = pc_q;
  assign o_rsp_mask  = mask_q;

endmodule

// File: tb/tb_imem_banked_fetch.sv
// Randomised and directed bench for imem_banked_fetch (FW=2, DEPTH=16)
// against a word-array reference model of fetch, stall and flush.
module tb_imem_banked_fetch;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int D  = 16;
  localparam int FW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [AW-1:0]     req_addr = '0;
  logic              flush = 1'b0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [AW-1:0]     rsp_pc;
  logic [FW*DW-1:0]  rsp_data;
  logic [FW-1:0]     rsp_mask;
  logic              wr_en = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [DW-1:0]     wr_data = '0;

  imem_banked_fetch #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .DEPTH(D), .FETCH_WIDTH(FW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_addr(req_addr), .i_flush(flush),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_pc(rsp_pc), .o_rsp_data(rsp_data),
    .o_rsp_mask(rsp_mask), .i_wr_en(wr_en),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0]    mm [D];
  logic             ev = 1'b0;
  logic [AW-1:0]    epc = '0;
  logic [FW*DW-1:0] edata = '0;
  logic [FW-1:0]    emask = '0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rv, input logic [AW-1:0] a,
                      input logic fl, input logic rr,
                      input logic we, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd);
    int w;
    logic acc;
    req_valid = rv; req_addr = a; flush = fl;
    rsp_ready = rr; wr_en = we; wr_addr = wa; wr_data = wd;
    #1;
    chk("req_ready", 64'(req_ready), 64'(fl | !ev | rr));
    @(posedge clk);
    acc = rv && (fl || !ev || rr);
    if (acc) begin
      w = int'((a >> 2) % D);
      ev  = 1'b1;
      epc = a & ~32'h3;
      for (int k = 0; k < FW; k++) begin
        edata[k*DW +: DW] = mm[(w + k) % D];
`ifdef IMEM_FETCH_LINE_CLIP_EN
        emask[k] = ((w % FW) + k) < FW;
`else
        emask[k] = 1'b1;
`endif
      end
    end else if (fl || rr) begin
      ev = 1'b0;
    end
    if (we) mm[(wa >> 2) % D] = wd;
    #1;
    chk("rsp_valid", 64'(rsp_valid), 64'(ev));
    if (ev) begin
      chk("rsp_pc", 64'(rsp_pc), 64'(epc));
      chk("rsp_data", 64'(rsp_data), 64'(edata));
      chk("rsp_mask", 64'(rsp_mask), 64'(emask));
    end
  endtask

  initial begin
    #2;
    chk("rst_valid", 64'(rsp_valid), 64'(0));
    chk("rst_pc", 64'(rsp_pc), 64'(0));
    chk("rst_data", 64'(rsp_data), 64'(0));
    chk("rst_mask", 64'(rsp_mask), 64'(0));
    #10 rst_n = 1'b1;

    for (int i = 0; i < D; i++)
      step(0, 0, 0, 1, 1, 32'(i * 4), 32'(32'h100 + i));

    step(1, 32'h08, 0, 1, 0, 0, 0);
    chk("aligned", 64'(rsp_data), 64'h00000103_00000102);
    step(1, 32'h0C, 0, 1, 0, 0, 0);
    chk("misalign", 64'(rsp_data), 64'h00000104_00000103);
    step(1, 32'h3C, 0, 1, 0, 0, 0);
    chk("wrap", 64'(rsp_data), 64'h00000100_0000010F);

    step(1, 32'h00, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step(1, 32'h10, 0, 0, 0, 0, 0);
    chk("stall_pc", 64'(rsp_pc), 64'h0);
    step(1, 32'h10, 0, 1, 0, 0, 0);
    chk("unstall_pc", 64'(rsp_pc), 64'h10);

    step(1, 32'h00, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h00, 32'hBEEF);
    step(1, 32'h20, 1, 0, 0, 0, 0);
    chk("flush_data", 64'(rsp_data), 64'h00000109_00000108);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);

    step(1, 32'h14, 0, 1, 1, 32'h14, 32'hDEAD);
    chk("rbw_old", 64'(rsp_data[31:0]), 64'h105);
    step(1, 32'h14, 0, 1, 0, 0, 0);
    chk("rbw_new", 64'(rsp_data[31:0]), 64'hDEAD);

    step(1, 32'h08, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", 64'(rsp_valid), 64'(0));
    ev = 1'b0; epc = '0;
    #1 rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom(),
           1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 3) == 0), $urandom(),
           $urandom());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
